// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: MULT/DIV families, multiply-accumulate,
// and direct HI/LO writes. Results land on the edge where busy falls.
module mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] LAST      = CW'(1);

    logic [0:0]       state;
    logic [CW-1:0]    counter;
    logic [2:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;

    // Even op codes in 0-7 are the signed variants; ops 2-3 are the divides.
    logic signedOp;
    logic isDiv;
    assign signedOp = ~opReg[0];
    assign isDiv    = (opReg[2:1] == 2'b01);
    assign busy     = (state == RUN);

    logic [2*WIDTH-1:0] mulA, mulB, product, mulResult;

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        mulA    = {{WIDTH{signedOp & aReg[WIDTH-1]}}, aReg};
        mulB    = {{WIDTH{signedOp & bReg[WIDTH-1]}}, bReg};
        product = mulA * mulB;
        mulResult = product;
        if (opReg[2]) begin
            mulResult = opReg[1] ? ({hi, lo} - product) : ({hi, lo} + product);
        end
    end

    logic             aNeg, bNeg;
    logic [WIDTH-1:0] absA, absB, quotU, remU, quot, rem;

    // Divide on magnitudes, then restore signs; most-negative / -1 wraps to A.
    always_comb begin
        aNeg  = signedOp & aReg[WIDTH-1];
        bNeg  = signedOp & bReg[WIDTH-1];
        absA  = aNeg ? -aReg : aReg;
        absB  = bNeg ? -bReg : bReg;
        quotU = '1;
        remU  = absA;
        if (bReg != '0) begin
            quotU = absA / absB;
            remU  = absA % absB;
        end
        quot = '1;
        rem  = aReg;
        if (bReg != '0) begin
            quot = (aNeg ^ bNeg) ? -quotU : quotU;
            rem  = aNeg ? -remU : remU;
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            opReg   <= '0;
            aReg    <= '0;
            bReg    <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (state == IDLE) begin
            if (start && !flush) begin
                if (!op[3]) begin
                    state   <= RUN;
                    counter <= (op[2:1] == 2'b01) ? DIV_LOAD : MULT_LOAD;
                    opReg   <= op[2:0];
                    aReg    <= A;
                    bReg    <= B;
                end else if (op == 4'd8) begin
                    hi <= A;
                end else if (op == 4'd9) begin
                    lo <= A;
                end
            end
        end else begin
            if (counter == LAST) begin
                state   <= IDLE;
                counter <= '0;
                if (isDiv) begin
                    hi <= rem;
                    lo <= quot;
                end else begin
                    {hi, lo} <= mulResult;
                end
            end else begin
                counter <= counter - LAST;
            end
        end
    end
endmodule
